// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: instruction codes, FSM states
// and the byte-count decode used by the byte-serial access engine.
package mem_stage_pkg;

  localparam int INST_IDX_W = 5;

  localparam logic [INST_IDX_W-1:0] INST_NOP = 5'd0;
  localparam logic [INST_IDX_W-1:0] INST_ADD = 5'd1;
  localparam logic [INST_IDX_W-1:0] INST_LB  = 5'd8;
  localparam logic [INST_IDX_W-1:0] INST_LH  = 5'd9;
  localparam logic [INST_IDX_W-1:0] INST_LW  = 5'd10;
  localparam logic [INST_IDX_W-1:0] INST_LBU = 5'd11;
  localparam logic [INST_IDX_W-1:0] INST_LHU = 5'd12;
  localparam logic [INST_IDX_W-1:0] INST_SB  = 5'd13;
  localparam logic [INST_IDX_W-1:0] INST_SH  = 5'd14;
  localparam logic [INST_IDX_W-1:0] INST_SW  = 5'd15;

  localparam logic [2:0] BYTES_NONE = 3'd0;
  localparam logic [2:0] BYTES_B    = 3'd1;
  localparam logic [2:0] BYTES_H    = 3'd2;
  localparam logic [2:0] BYTES_W    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  // Zero bytes marks a non-memory instruction.
  function automatic logic [2:0] op_bytes(input logic [INST_IDX_W-1:0] op);
    case (op)
      INST_LB, INST_LBU, INST_SB: return BYTES_B;
      INST_LH, INST_LHU, INST_SH: return BYTES_H;
      INST_LW, INST_SW:           return BYTES_W;
      default:                    return BYTES_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [INST_IDX_W-1:0] op);
    return op inside {INST_SB, INST_SH, INST_SW};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide memory bus between the memory stage (master) and the memory (slave).
interface mem_stage_if #(
  parameter int XLEN   = 32,
  parameter int BYTE_W = 8
);
  logic              mem_req_out;
  logic              mem_we_out;
  logic [XLEN-1:0]   mem_addr_out;
  logic [BYTE_W-1:0] mem_wdata_out;
  logic              mem_ack_in;
  logic [BYTE_W-1:0] mem_rdata_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_ack_in, mem_rdata_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_ack_in, mem_rdata_in
  );
endinterface

// File: rtl/mem_load_ext.sv
// Width and sign extension of the assembled load buffer.
module mem_load_ext
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BYTE_W = 8
) (
  input  logic [INST_IDX_W-1:0] op_in,
  input  logic [XLEN-1:0]       buf_in,
  output logic [XLEN-1:0]       data_out
);

  always_comb begin
    data_out = buf_in;
    case (op_in)
      INST_LB:  data_out = {{(XLEN-BYTE_W){buf_in[BYTE_W-1]}}, buf_in[BYTE_W-1:0]};
      INST_LBU: data_out = {{(XLEN-BYTE_W){1'b0}}, buf_in[BYTE_W-1:0]};
      INST_LH:  data_out = {{(XLEN-2*BYTE_W){buf_in[2*BYTE_W-1]}}, buf_in[2*BYTE_W-1:0]};
      INST_LHU: data_out = {{(XLEN-2*BYTE_W){1'b0}}, buf_in[2*BYTE_W-1:0]};
      default:  data_out = buf_in;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: serialises loads/stores into little-endian byte
// accesses on a byte-wide bus, stalling the pipeline until the access is done.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BYTE_W = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [INST_IDX_W-1:0] instIdx_in,
  input  logic [XLEN-1:0]       memAddr_in,
  input  logic [XLEN-1:0]       valStore_in,
  input  logic                  rdE_in,
  input  logic [4:0]            rdIdx_in,
  input  logic [XLEN-1:0]       rdData_in,
  mem_stage_if.master           mem_bus,
  output logic                  rdE_out,
  output logic [4:0]            rdIdx_out,
  output logic [XLEN-1:0]       rdData_out,
  output logic                  stallReq_out
);

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [XLEN-1:0]   buf_q, buf_d;

  logic [2:0]        n_bytes;
  logic              is_mem;
  logic              is_store;
  logic              last_byte;
  logic [XLEN-1:0]   ext_data;

  assign n_bytes   = op_bytes(instIdx_in);
  assign is_mem    = (n_bytes != BYTES_NONE);
  assign is_store  = op_is_store(instIdx_in);
  assign last_byte = ({1'b0, k_q} == (n_bytes - 3'd1));

  mem_load_ext #(
    .XLEN   (XLEN),
    .BYTE_W (BYTE_W)
  ) u_load_ext (
    .op_in    (instIdx_in),
    .buf_in   (buf_q),
    .data_out (ext_data)
  );

  always_comb begin
    state_d               = state_q;
    k_d                   = k_q;
    buf_d                 = buf_q;
    mem_bus.mem_req_out   = 1'b0;
    mem_bus.mem_we_out    = 1'b0;
    mem_bus.mem_addr_out  = '0;
    mem_bus.mem_wdata_out = '0;
    stallReq_out          = 1'b0;
    rdE_out               = 1'b0;
    rdIdx_out             = '0;
    rdData_out            = '0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          stallReq_out = 1'b1;
          if (rdy_in) begin
            state_d = ST_ACCESS;
            k_d     = '0;
            buf_d   = '0;
          end
        end else begin
          rdE_out    = rdE_in;
          rdIdx_out  = rdIdx_in;
          rdData_out = rdData_in;
        end
      end
      ST_ACCESS: begin
        mem_bus.mem_req_out   = 1'b1;
        mem_bus.mem_we_out    = is_store;
        mem_bus.mem_addr_out  = memAddr_in + {{(XLEN-2){1'b0}}, k_q};
        mem_bus.mem_wdata_out = valStore_in[BYTE_W*int'(k_q) +: BYTE_W];
        stallReq_out          = 1'b1;
        // Acks are only honoured while the pipeline is running.
        if (rdy_in && mem_bus.mem_ack_in) begin
          if (!is_store) begin
            buf_d[BYTE_W*int'(k_q) +: BYTE_W] = mem_bus.mem_rdata_in;
          end
          if (last_byte) begin
            state_d = ST_DONE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (!is_store) begin
          rdE_out    = rdE_in;
          rdIdx_out  = rdIdx_in;
          rdData_out = ext_data;
        end
        if (rdy_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are quiet for as long as reset is held, even in pass-through.
    if (!rst_in) begin
      mem_bus.mem_req_out   = 1'b0;
      mem_bus.mem_we_out    = 1'b0;
      mem_bus.mem_addr_out  = '0;
      mem_bus.mem_wdata_out = '0;
      stallReq_out          = 1'b0;
      rdE_out               = 1'b0;
      rdIdx_out             = '0;
      rdData_out            = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      buf_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter BYTE_W, default 8, memory bus width.
REQ-003 SHALL have port clk_in, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port rst_in, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in, input, 1, global ready; 0 freezes all state.
REQ-006 SHALL have port instIdx_in, input, INST_IDX_W, instruction id from EX/MEM register.
REQ-007 SHALL have ports memAddr_in (input, XLEN, byte address) and valStore_in (input, XLEN, store data).
REQ-008 SHALL have ports rdE_in (input, 1), rdIdx_in (input, 5) and rdData_in (input, XLEN): writeback request from EX.
REQ-009 SHALL have ports mem_req_out (output, 1, byte access request), mem_we_out (output, 1, 1=write), mem_addr_out (output, XLEN) and mem_wdata_out (output, BYTE_W).
REQ-010 SHALL have ports mem_ack_in (input, 1, current byte done) and mem_rdata_in (input, BYTE_W, read byte, valid with ack).
REQ-011 SHALL have ports rdE_out (output, 1), rdIdx_out (output, 5) and rdData_out (output, XLEN): to MEM/WB and forwarding.
REQ-012 SHALL have port stallReq_out, output, 1, stall request to the pipeline controller.

Function
REQ-013 Non-memory instruction in IDLE SHALL pass rdE/rdIdx/rdData through combinationally, with stallReq_out=0.
REQ-014 Memory ops SHALL be LB/LH/LW/LBU/LHU/SB/SH/SW, with byte count N of 1/2/4.
REQ-015 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-016 IDLE with a memory op and rdy_in=1 SHALL assert stallReq_out combinationally, clear byte index k to 0, and enter ACCESS at the next edge.
REQ-017 In ACCESS, outputs SHALL be mem_req_out=1, mem_addr_out=memAddr_in+k (mod 2^XLEN), mem_we_out=1 for stores, mem_wdata_out=valStore_in[8k+7:8k], and stallReq_out=1.
REQ-018 In ACCESS, rdE_out SHALL be 0.
REQ-019 Little-endian: each ack on a load SHALL store mem_rdata_in into buffer byte k, then increment k.
REQ-020 An ack with k=N-1 SHALL move the FSM to DONE at the same edge.
REQ-021 In DONE (one cycle), outputs SHALL be stallReq_out=0 and mem_req_out=0.
REQ-022 In DONE, a load SHALL output rdE_out=rdE_in, rdIdx_out=rdIdx_in and rdData_out=extended buffer.
REQ-023 In DONE, a store SHALL output rdE_out=0; the FSM then returns to IDLE.
REQ-024 Extension SHALL be sign for LB/LH, zero for LBU/LHU, none for LW.
REQ-025 Misaligned addresses SHALL be legal and need no special handling; address wraps at 2^XLEN.
REQ-026 While rdy_in=0, state, k and buffer SHALL hold and mem_ack_in SHALL be ignored.
REQ-027 Minimum latency SHALL be N+2 cycles (IDLE detect, N ack cycles, DONE).
REQ-028 mem_req_out SHALL stay high between consecutive acks; no idle cycle between bytes.

Reset
REQ-029 rst_in=0 SHALL immediately force IDLE, k=0 and buffer=0, including mid-access.
REQ-030 While in reset, outputs SHALL be mem_req_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0, stallReq_out=0, rdE_out=0, rdIdx_out=0 and rdData_out=0.
REQ-031 An in-flight access SHALL be abandoned on reset; no partial writeback.

Structure
REQ-032 The shared package SHALL hold the instIdx codes, INST_IDX_W, the FSM state enum, and the byte-count decode constants.
REQ-033 A combinational sub-module mem_load_ext SHALL perform width/sign extension.
REQ-034 All sequential state SHALL sit in mem_stage.

Verification
REQ-035 LW at 0x1000, acks every cycle, bytes 0x78,0x56,0x34,0x12 -> rdData_out=0x12345678 in DONE; stall for 5 cycles.
REQ-036 LB at 0x2003, byte 0x80 -> rdData_out=0xFFFFFF80; LBU, same byte -> 0x00000080.
REQ-037 SH, valStore=0xAABBCCDD, addr 0x3FFF -> writes 0xDD@0x3FFF, 0xCC@0x4000; rdE_out=0 throughout.
REQ-038 LW with ack gaps, plus rdy_in=0 for 3 cycles mid-access -> k frozen, correct result, stall held.
REQ-039 rst_in low during the 2nd byte of SW -> mem_req_out=0 immediately, IDLE, no DONE cycle.
REQ-040 ADD (rdE=1, rd=5, 0x7) followed by LW -> pass-through with no stall, then LW stalls.
